execute_stage_md: RTL and testbench

Parametrised execute stage for the 5-stage RISC-V pipeline, sitting between decode and memory. Adds an iterative RV32M multiply/divide unit, N-way operand forwarding and a downstream stall handshake. Single-cycle ALU ops complete in the cycle they occupy the stage register. MUL/DIV ops hold the stage and raise a stall request until done.

---
 rtl/exec_pkg.sv | 32 +++
 rtl/alu.sv | 33 +++
 rtl/mul_div_iter.sv | 148 ++++++++++++++
 rtl/execute_stage_md.sv | 130 +++++++++++++
 tb/tb_execute_stage_md.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the execute stage
package exec_pkg;

  localparam int XLEN_DEF = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  // one-hot ALU op bit positions
  localparam int ALU_W    = 11;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;
  localparam int ALU_LUI  = 10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - one-hot single-cycle integer ALU
module alu
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [ALU_W-1:0] op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic [XLEN-1:0]  y_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    y_o = '0;
    if (op_i[ALU_ADD])  y_o = a_i + b_i;
    if (op_i[ALU_SUB])  y_o = a_i - b_i;
    if (op_i[ALU_SLL])  y_o = a_i << shamt;
    if (op_i[ALU_SLT])  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
    if (op_i[ALU_SLTU]) y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
    if (op_i[ALU_XOR])  y_o = a_i ^ b_i;
    if (op_i[ALU_SRL])  y_o = a_i >> shamt;
    if (op_i[ALU_SRA])  y_o = $unsigned($signed(a_i) >>> shamt);
    if (op_i[ALU_OR])   y_o = a_i | b_i;
    if (op_i[ALU_AND])  y_o = a_i & b_i;
    if (op_i[ALU_LUI])  y_o = b_i;
  end

endmodule

// File: rtl/mul_div_iter.sv
// rtl/mul_div_iter.sv - iterative RV32M multiply/divide, one bit per cycle
module mul_div_iter
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            consume,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            a_neg, b_neg, ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = op[2] ? (!op[0] && a[XLEN-1])
                       : ((op == MD_MULH || op == MD_MULHSU) && a[XLEN-1]);
  assign b_neg = op[2] ? (!op[0] && b[XLEN-1]) : ((op == MD_MULH) && b[XLEN-1]);
  assign a_mag = a_neg ? ('0 - a) : a;
  assign b_mag = b_neg ? ('0 - b) : b;
  assign ovf   = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);

  // Multiply: multiplier in low half, shift-add into high half.
  // Divide: remainder in high half, quotient bits shift in from the bottom.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvs_q};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    if (op_q[2]) begin
      acc_step = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  always_comb begin
    prod = qneg_q ? ('0 - acc_step) : acc_step;
    case (op_q)
      MD_MUL:                       fix_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = qneg_q ? ('0 - acc_step[XLEN-1:0]) : acc_step[XLEN-1:0];
      default:                      fix_res = rneg_q ? ('0 - acc_step[2*XLEN-1:XLEN])
                                                     : acc_step[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy   = 1'b1;
          op_d   = op;
          cnt_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (op[2]) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            dvs_d = b_mag;
            if (b == '0) begin
              res_d   = op[1] ? a : '1;
              state_d = DONE;
            end else if (ovf) begin
              res_d   = op[1] ? '0 : a;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            dvs_d   = a_mag;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        busy  = 1'b1;
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          res_d   = fix_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (consume) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign done = (state_q == DONE);
  assign res  = res_q;

endmodule

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - execute stage with forwarding, ALU and iterative mul/div
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int FWD_SRCS = 2,
  parameter int SIDE_W   = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     stall_i,
  input  logic                     is_md,
  input  logic [2:0]               md_op,
  input  logic [ALU_W-1:0]         alu_op,
  input  logic                     src1_is_pc,
  input  logic                     src2_is_4,
  input  logic                     src2_is_imm,
  input  logic [XLEN-1:0]          imm,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [XLEN-1:0]          pc,
  input  logic [SIDE_W-1:0]        side_i,
  input  logic [FWD_SRCS-1:0]      fwd_sel1,
  input  logic [FWD_SRCS-1:0]      fwd_sel2,
  input  logic [FWD_SRCS*XLEN-1:0] fwd_data,
  output logic                     out_valid,
  output logic [XLEN-1:0]          result,
  output logic [XLEN-1:0]          store_data,
  output logic [XLEN-1:0]          pc_o,
  output logic [SIDE_W-1:0]        side_o,
  output logic                     busy
);

  logic              valid_q, valid_d, load;
  logic              is_md_q, src1_is_pc_q, src2_is_4_q, src2_is_imm_q;
  logic [2:0]        md_op_q;
  logic [ALU_W-1:0]  alu_op_q;
  logic [XLEN-1:0]   imm_q, rs1_q, rs2_q, pc_q;
  logic [SIDE_W-1:0] side_q;

  logic            md_busy, md_done;
  logic [XLEN-1:0] md_res, alu_y;
  logic [XLEN-1:0] rs1_res, rs2_res, src1, src2;

  assign in_ready = !md_busy && !stall_i;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush)         valid_d = 1'b0;
    else if (in_ready) valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      is_md_q       <= 1'b0;
      md_op_q       <= '0;
      alu_op_q      <= '0;
      src1_is_pc_q  <= 1'b0;
      src2_is_4_q   <= 1'b0;
      src2_is_imm_q <= 1'b0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      pc_q          <= '0;
      side_q        <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        is_md_q       <= is_md;
        md_op_q       <= md_op;
        alu_op_q      <= alu_op;
        src1_is_pc_q  <= src1_is_pc;
        src2_is_4_q   <= src2_is_4;
        src2_is_imm_q <= src2_is_imm;
        imm_q         <= imm;
        rs1_q         <= rs1_data;
        rs2_q         <= rs2_data;
        pc_q          <= pc;
        side_q        <= side_i;
      end
    end
  end

  // Walk from the oldest source down so the lowest set index wins.
  always_comb begin
    rs1_res = rs1_q;
    rs2_res = rs2_q;
    for (int k = FWD_SRCS - 1; k >= 0; k--) begin
      if (fwd_sel1[k]) rs1_res = fwd_data[k*XLEN +: XLEN];
      if (fwd_sel2[k]) rs2_res = fwd_data[k*XLEN +: XLEN];
    end
  end

  assign src1 = src1_is_pc_q ? pc_q : rs1_res;
  assign src2 = src2_is_4_q ? XLEN'(4) : (src2_is_imm_q ? imm_q : rs2_res);

  alu #(.XLEN(XLEN)) u_alu (
    .op_i (alu_op_q),
    .a_i  (src1),
    .b_i  (src2),
    .y_o  (alu_y)
  );

  mul_div_iter #(.XLEN(XLEN)) u_md (
    .clk     (clk),
    .reset   (reset),
    .start   (valid_q && is_md_q),
    .op      (md_op_q),
    .a       (rs1_res),
    .b       (rs2_res),
    .flush   (flush),
    .consume (!stall_i),
    .busy    (md_busy),
    .done    (md_done),
    .res     (md_res)
  );

  assign busy       = md_busy;
  assign out_valid  = valid_q && (!is_md_q || md_done);
  assign result     = is_md_q ? md_res : alu_y;
  assign store_data = rs2_res;
  assign pc_o       = pc_q;
  assign side_o     = side_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - directed vector bench for execute_stage_md
module tb_execute_stage_md;
  import exec_pkg::*;

  localparam int XLEN = 32;
  localparam int FWD_SRCS = 2;
  localparam int SIDE_W = 11;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush, stall_i, is_md;
  logic [2:0] md_op;
  logic [ALU_W-1:0] alu_op;
  logic src1_is_pc, src2_is_4, src2_is_imm;
  logic [XLEN-1:0] imm, rs1_data, rs2_data, pc;
  logic [SIDE_W-1:0] side_i, side_o;
  logic [FWD_SRCS-1:0] fwd_sel1, fwd_sel2;
  logic [FWD_SRCS*XLEN-1:0] fwd_data;
  logic out_valid, busy;
  logic [XLEN-1:0] result, store_data, pc_o;

  int checks = 0;
  int errors = 0;

  execute_stage_md #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS), .SIDE_W(SIDE_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .stall_i(stall_i), .is_md(is_md), .md_op(md_op),
    .alu_op(alu_op), .src1_is_pc(src1_is_pc), .src2_is_4(src2_is_4),
    .src2_is_imm(src2_is_imm), .imm(imm), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .pc(pc), .side_i(side_i), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .fwd_data(fwd_data), .out_valid(out_valid),
    .result(result), .store_data(store_data), .pc_o(pc_o), .side_o(side_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [ALU_W-1:0] op;
    logic pc1, s4, simm;
    logic [31:0] imm, rs1, rs2, pc;
    logic [1:0] fs1, fs2;
    logic [31:0] f0, f1, exp_res, exp_st;
  } alu_vec_t;

  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b, exp_res;
    int exp_lat;
  } md_vec_t;

  alu_vec_t av[15];
  md_vec_t mv[16];

  function automatic logic [ALU_W-1:0] oh(input int i);
    logic [ALU_W-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; is_md = 0; md_op = 0; alu_op = 0;
    src1_is_pc = 0; src2_is_4 = 0; src2_is_imm = 0;
    imm = 0; rs1_data = 0; rs2_data = 0; pc = 0; side_i = 0;
    fwd_sel1 = 0; fwd_sel2 = 0; fwd_data = 0; flush = 0; stall_i = 0;
  endtask

  // Issue one MD op; forwarding only valid in cycle 1, then scrambled.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] fs1, input logic [31:0] f0,
                        output int lat, output int bcnt, output logic [31:0] r);
    tick();
    in_valid = 1; is_md = 1; md_op = op; rs1_data = a; rs2_data = b;
    tick();
    idle_inputs();
    md_op = op;
    fwd_sel1 = fs1;
    fwd_data = {32'h0, f0};
    lat = 0; bcnt = 0; r = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (out_valid) begin
        lat = c;
        r = result;
        break;
      end
      tick();
      fwd_data = {32'h0BAD0BAD, 32'hDEADBEEF};
    end
  endtask

  initial begin
    int lat, bcnt, cnt, found;
    logic [31:0] r;

    av[0]  = '{oh(ALU_ADD), 0, 0, 0, 32'h0, 32'd5, 32'd7, 32'h40, 2'b01, 2'b00, 32'd100, 32'd0, 32'd107, 32'd7};
    av[1]  = '{oh(ALU_ADD), 0, 0, 0, 32'h0, 32'd1, 32'd2, 32'h44, 2'b00, 2'b11, 32'd30, 32'd20, 32'd31, 32'd30};
    av[2]  = '{oh(ALU_SUB), 0, 0, 0, 32'h0, 32'd10, 32'd3, 32'h48, 2'b00, 2'b00, 32'd0, 32'd0, 32'd7, 32'd3};
    av[3]  = '{oh(ALU_ADD), 1, 1, 0, 32'h0, 32'd0, 32'd9, 32'h100, 2'b00, 2'b00, 32'd0, 32'd0, 32'h104, 32'd9};
    av[4]  = '{oh(ALU_ADD), 0, 0, 1, 32'hFFFFFFF0, 32'h20, 32'h77, 32'h4C, 2'b00, 2'b00, 32'd0, 32'd0, 32'h10, 32'h77};
    av[5]  = '{oh(ALU_SLT), 0, 0, 0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h50, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1, 32'd1};
    av[6]  = '{oh(ALU_SLTU), 0, 0, 0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h54, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd1};
    av[7]  = '{oh(ALU_SRA), 0, 0, 0, 32'h0, 32'h80000000, 32'd4, 32'h58, 2'b00, 2'b00, 32'd0, 32'd0, 32'hF8000000, 32'd4};
    av[8]  = '{oh(ALU_XOR), 0, 0, 0, 32'h0, 32'h0, 32'hFF, 32'h5C, 2'b10, 2'b00, 32'h11, 32'h55, 32'hAA, 32'hFF};
    av[9]  = '{oh(ALU_ADD), 0, 1, 1, 32'd100, 32'd8, 32'd3, 32'h60, 2'b00, 2'b00, 32'd0, 32'd0, 32'd12, 32'd3};
    av[10] = '{oh(ALU_SLL), 0, 0, 0, 32'h0, 32'd1, 32'd31, 32'h64, 2'b00, 2'b00, 32'd0, 32'd0, 32'h80000000, 32'd31};
    av[11] = '{oh(ALU_AND), 0, 0, 0, 32'h0, 32'hF0F0, 32'h0, 32'h68, 2'b00, 2'b10, 32'h1, 32'h0FF0, 32'h00F0, 32'h0FF0};
    av[12] = '{oh(ALU_LUI), 0, 0, 1, 32'h12345000, 32'd7, 32'd0, 32'h6C, 2'b00, 2'b00, 32'd0, 32'd0, 32'h12345000, 32'd0};
    av[13] = '{oh(ALU_SRL), 0, 0, 0, 32'h0, 32'h80000000, 32'd4, 32'h70, 2'b00, 2'b00, 32'd0, 32'd0, 32'h08000000, 32'd4};
    av[14] = '{oh(ALU_OR), 0, 0, 0, 32'h0, 32'hF0, 32'h0F, 32'h74, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFF, 32'h0F};

    mv[0]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    mv[1]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    mv[2]  = '{MD_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 2};
    mv[3]  = '{MD_REMU,   32'h1234,     32'd0,        32'h1234,     2};
    mv[4]  = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    mv[5]  = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        2};
    mv[6]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    mv[7]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    mv[8]  = '{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    mv[9]  = '{MD_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34};
    mv[10] = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       34};
    mv[11] = '{MD_REMU,   32'd100,      32'd7,        32'd2,        34};
    mv[12] = '{MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    mv[13] = '{MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};
    mv[14] = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    mv[15] = '{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2};

    idle_inputs();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_store", store_data, 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_side_o", 32'(side_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (av[i]) begin
      tick();
      in_valid = 1; alu_op = av[i].op;
      src1_is_pc = av[i].pc1; src2_is_4 = av[i].s4; src2_is_imm = av[i].simm;
      imm = av[i].imm; rs1_data = av[i].rs1; rs2_data = av[i].rs2; pc = av[i].pc;
      side_i = 11'h5A5;
      tick();
      idle_inputs();
      fwd_sel1 = av[i].fs1; fwd_sel2 = av[i].fs2;
      fwd_data = {av[i].f1, av[i].f0};
      @(negedge clk);
      chk($sformatf("alu%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("alu%0d_result", i), result, av[i].exp_res);
      chk($sformatf("alu%0d_store", i), store_data, av[i].exp_st);
      chk($sformatf("alu%0d_pc_o", i), pc_o, av[i].pc);
      chk($sformatf("alu%0d_side", i), 32'(side_o), 32'h5A5);
    end
    tick();
    idle_inputs();

    foreach (mv[i]) begin
      run_md(mv[i].op, mv[i].a, mv[i].b, 2'b00, 32'd0, lat, bcnt, r);
      chk($sformatf("md%0d_latency", i), 32'(lat), 32'(mv[i].exp_lat));
      chk($sformatf("md%0d_busy_cycles", i), 32'(bcnt), 32'(mv[i].exp_lat - 1));
      chk($sformatf("md%0d_result", i), r, mv[i].exp_res);
    end

    // dividend comes from forwarding in the IDLE cycle only
    run_md(MD_DIVU, 32'd0, 32'd5, 2'b01, 32'd50, lat, bcnt, r);
    chk("md_fwd_sample_result", r, 32'd10);
    chk("md_fwd_sample_latency", 32'(lat), 32'd34);

    // flush during RUN
    tick();
    in_valid = 1; is_md = 1; md_op = MD_MUL; rs1_data = 32'd3; rs2_data = 32'd5;
    tick();
    idle_inputs();
    for (int c = 2; c <= 10; c++) tick();
    flush = 1;
    @(negedge clk);
    chk("flush_busy_before", 32'(busy), 32'd1);
    tick();
    flush = 0;
    @(negedge clk);
    chk("flush_busy_after", 32'(busy), 32'd0);
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("flush_no_late_valid", 32'(cnt), 32'd0);
    tick();
    in_valid = 1; alu_op = oh(ALU_ADD); rs1_data = 32'd2; rs2_data = 32'd3;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("post_flush_add_valid", 32'(out_valid), 32'd1);
    chk("post_flush_add_result", result, 32'd5);

    // stall held three cycles in DONE, then back-to-back ADD
    tick();
    in_valid = 1; is_md = 1; md_op = MD_MULHU; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    found = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("stall_done_seen", 32'(found), 32'd1);
    stall_i = 1; in_valid = 1; alu_op = oh(ALU_ADD); rs1_data = 32'd1; rs2_data = 32'd1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_result", k), result, 32'hFFFFFFFE);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    tick();
    stall_i = 0;
    @(negedge clk);
    chk("unstall_valid", 32'(out_valid), 32'd1);
    chk("unstall_result", result, 32'hFFFFFFFE);
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("b2b_add_valid", 32'(out_valid), 32'd1);
    chk("b2b_add_result", result, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
